// File: rtl/ksa_shuffle_if.sv
// ksa_shuffle_if: start/status, key-byte handshake and S-box RAM port of the RC4 KSA engine
interface ksa_shuffle_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       key_start;
  logic [7:0] key_index;
  logic       key_finish;
  logic [7:0] key_byte;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_wren;
  logic [7:0] mem_q;
  modport master (
    input  start, key_finish, key_byte, mem_q,
    output busy, done, key_start, key_index, mem_address, mem_data, mem_wren
  );
  modport slave (
    output start, key_finish, key_byte, mem_q,
    input  busy, done, key_start, key_index, mem_address, mem_data, mem_wren
  );
endinterface

// File: rtl/ksa_shuffle.sv
// ksa_shuffle: RC4 key-scheduling pass, j += S[i] + key[i] and swap S[i]/S[j] in external RAM
module ksa_shuffle #(
  parameter int LAST_INDEX = 255
) (
  input  logic         clk,
  input  logic         reset_n,
  ksa_shuffle_if.master bus
);
  localparam logic [7:0] LAST = 8'(LAST_INDEX);
  typedef enum logic [3:0] {IDLE, REQ, WAIT_I, WAIT_KEY, RD_J, CAP_J, WR_I, WR_J, NEXT, DONE} state_t;
  state_t state, state_n;
  logic [7:0] i, j, si, sj, key_r;
  logic       key_valid;
  logic [7:0] key_sel;
  logic       key_ready;
  logic       key_win;
  assign key_sel   = bus.key_finish ? bus.key_byte : key_r;
  assign key_ready = key_valid || bus.key_finish;
  // a finish arriving while the S[i] read is still in flight is banked for WAIT_KEY
  assign key_win   = (state == WAIT_I) || (state == WAIT_KEY);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      i         <= '0;
      j         <= '0;
      si        <= '0;
      sj        <= '0;
      key_r     <= '0;
      key_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        i <= '0;
        j <= '0;
      end
      if (state == REQ) key_valid <= 1'b0;
      if (key_win && bus.key_finish) begin
        key_r     <= bus.key_byte;
        key_valid <= 1'b1;
      end
      if (state == WAIT_I) si <= bus.mem_q;
      if (state == WAIT_KEY && key_ready) j <= j + si + key_sel;
      if (state == CAP_J) sj <= bus.mem_q;
      if (state == NEXT && i != LAST) i <= i + 8'd1;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = bus.start ? REQ : IDLE;
      REQ:      state_n = WAIT_I;
      WAIT_I:   state_n = WAIT_KEY;
      WAIT_KEY: state_n = key_ready ? RD_J : WAIT_KEY;
      RD_J:     state_n = CAP_J;
      CAP_J:    state_n = WR_I;
      WR_I:     state_n = WR_J;
      WR_J:     state_n = NEXT;
      NEXT:     state_n = (i == LAST) ? DONE : REQ;
      default:  state_n = IDLE;
    endcase
  end
  // writing S[j] last makes the i==j case a no-op
  assign bus.busy        = state != IDLE;
  assign bus.done        = state == DONE;
  assign bus.key_start   = state == REQ;
  assign bus.key_index   = bus.busy ? i : 8'd0;
  assign bus.mem_wren    = (state == WR_I) || (state == WR_J);
  assign bus.mem_address = (state == RD_J || state == CAP_J || state == WR_J) ? j :
                           (state == REQ || state == WAIT_I || state == WR_I) ? i : 8'd0;
  assign bus.mem_data    = (state == WR_I) ? sj : (state == WR_J) ? si : 8'd0;
endmodule

// File: tb/tb_ksa_shuffle.sv
// tb_ksa_shuffle: directed checks of the KSA engine with a latency-tunable key provider and S-box RAM model
module tb_ksa_shuffle;
  logic clk;
  logic reset_n;
  ksa_shuffle_if bus();
  ksa_shuffle #(.LAST_INDEX(255)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  logic [7:0] mem [256];
  logic [7:0] init_s [256];
  logic [7:0] q_r;
  assign bus.mem_q = q_r;
  always @(posedge clk) begin
    if (!reset_n) for (int k = 0; k < 256; k++) mem[k] <= init_s[k];
    else if (bus.mem_wren) mem[bus.mem_address] <= bus.mem_data;
    q_r <= mem[bus.mem_address];
  end
  logic [7:0] key_tab [3];
  int key_len = 3;
  int lat = 6;
  int kcnt = 0;
  logic [7:0] kidx;
  always @(posedge clk) begin
    bus.key_finish <= 1'b0;
    if (!reset_n) begin
      kcnt <= 0;
      bus.key_byte <= 8'd0;
    end else begin
      if (kcnt == 1) begin
        bus.key_finish <= 1'b1;
        bus.key_byte   <= key_tab[int'(kidx) % key_len];
      end
      if (kcnt != 0) kcnt <= kcnt - 1;
      if (bus.key_start) begin
        if (lat == 1) begin
          bus.key_finish <= 1'b1;
          bus.key_byte   <= key_tab[int'(bus.key_index) % key_len];
        end else kcnt <= lat - 1;
        kidx <= bus.key_index;
      end
    end
  end
  int cyc = 0, ks_cnt = 0, done_cnt = 0, wr_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.key_start) ks_cnt <= ks_cnt + 1;
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.mem_wren) wr_cnt <= wr_cnt + 1;
  end
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask
  logic [7:0] gold [256];
  initial begin
    int t0, t_a, ks0, dn0, wr0, nbad;
    logic [7:0] gj, tmp;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    key_tab   = '{8'h00, 8'h02, 8'h49};
    for (int k = 0; k < 256; k++) init_s[k] = 8'(k);
    for (int k = 0; k < 256; k++) gold[k] = 8'(k);
    gj = 8'd0;
    for (int k = 0; k < 256; k++) begin
      gj = gj + gold[k] + key_tab[k % 3];
      tmp = gold[k]; gold[k] = gold[gj]; gold[gj] = tmp;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_outs", {6'd0, bus.done, bus.key_start, bus.key_index, bus.mem_address, bus.mem_data, bus.mem_wren}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'd0, bus.busy}, 0);
    bus.start = 1'b1;
    t0 = cyc; ks0 = ks_cnt; dn0 = done_cnt; wr0 = wr_cnt;
    for (int c = 0; c < 200 && !(bus.key_start && bus.key_index == 8'd3); c++) @(negedge clk);
    chk("req3_seen", {31'd0, bus.key_start && bus.key_index == 8'd3}, 1);
    chk("s0", mem[0], 8'h00);
    chk("s1", mem[1], 8'h03);
    chk("s3", mem[3], 8'h01);
    chk("s2", mem[2], 8'h4E);
    chk("s4e", mem[8'h4E], 8'h02);
    for (int c = 0; c < 4000 && !bus.done; c++) @(negedge clk);
    chk("done_seen", {31'd0, bus.done}, 1);
    chk("done_cyc", cyc - t0, 1 + 256 * 12);
    chk("ks_count", ks_cnt - ks0, 256);
    chk("wr_count", wr_cnt - wr0, 512);
    nbad = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) nbad++;
    chk("golden_s", nbad, 0);
    @(negedge clk);
    chk("post_idle", {31'd0, bus.busy}, 0);
    @(negedge clk);
    chk("rerun_req", {23'd0, bus.key_start, bus.key_index}, {23'd0, 1'b1, 8'd0});
    chk("done_once", done_cnt - dn0, 1);
    bus.start = 1'b0;
    init_s[0] = 8'hFF;
    key_tab   = '{8'hFF, 8'hFF, 8'hFF};
    lat       = 1;
    do_reset();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 20 && !(bus.key_start && bus.key_index == 8'd0); c++) @(negedge clk);
    t_a = cyc;
    @(negedge clk);
    for (int c = 0; c < 40 && !(bus.key_start && bus.key_index == 8'd1); c++) @(negedge clk);
    chk("fast_iter", cyc - t_a, 8);
    chk("wrap_s0", mem[0], 8'hFE);
    chk("wrap_sfe", mem[8'hFE], 8'hFF);
    for (int c = 0; c < 100 && !(bus.key_index == 8'd5 && bus.mem_wren); c++) @(negedge clk);
    chk("wr_i5_seen", {31'd0, bus.key_index == 8'd5 && bus.mem_wren}, 1);
    init_s[0] = 8'h00;
    key_tab   = '{8'h00, 8'h02, 8'h49};
    lat       = 6;
    reset_n   = 1'b0;
    #1;
    chk("midrst_outs", {5'd0, bus.busy, bus.done, bus.key_start, bus.key_index, bus.mem_address, bus.mem_data, bus.mem_wren}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    bus.start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    chk("restart_req", {23'd0, bus.key_start, bus.key_index}, {23'd0, 1'b1, 8'd0});
    for (int c = 0; c < 50 && !bus.mem_wren; c++) @(negedge clk);
    chk("first_wr_cyc", cyc - t0, 10);
    chk("first_wr_addr", bus.mem_address, 8'd0);
    do_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ksa_shuffle.md
# ksa_shuffle

RC4 key-scheduling (KSA) engine that sits between the S-box RAM and the secret-key byte provider in the decryption datapath. It is the requesting side of the key-byte handshake: it issues an index, waits for the provider's finish, and consumes the returned key byte. For i = 0..LAST_INDEX it computes j = j + S[i] + key[i] (mod 256) and swaps S[i] and S[j] in the externally owned 256x8 S-box RAM. A separate init block must already have loaded S[i] = i.

## Interface
- LAST_INDEX, 255, final value of i; reduce only for short simulations.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a KSA pass; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the pass completes.
- key_start  out  1  one-cycle request pulse to the key provider.
- key_index  out  8  index i presented with key_start; held until the next request.
- key_finish  in  1  provider completion pulse; key_byte is valid in the same cycle.
- key_byte  in  8  key byte for key_index.
- mem_address  out  8  S-box RAM address.
- mem_data  out  8  S-box RAM write data.
- mem_wren  out  1  S-box RAM write enable.
- mem_q  in  8  S-box RAM read data. Address presented in cycle k gives read data that is sampled at the end of cycle k+1.

## Operation
- Registers: i[7:0], j[7:0], si[7:0], sj[7:0], key_r[7:0], key_valid.
- All arithmetic is 8-bit and wraps mod 256. j_next = j + si + key_r, truncated to 8 bits.
- IDLE: outputs low. If start=1: i←0, j←0, go to REQ. Otherwise stay.
- REQ:
  - Assert key_start=1 and key_index=i.
  - Drive mem_address=i with mem_wren=0.
  - Clear key_valid. Go to WAIT_I.
- WAIT_I: hold mem_address=i; si←mem_q at the end of the cycle. Go to WAIT_KEY.
- WAIT_KEY: stay until key_valid=1 or key_finish=1. On exit, j←j + si + (key_finish ? key_byte : key_r), then go to RD_J.
- RD_J: mem_address=j, mem_wren=0. Go to CAP_J.
- CAP_J: hold mem_address=j; sj←mem_q at the end of the cycle. Go to WR_I.
- WR_I: mem_address=i, mem_data=sj, mem_wren=1. Go to WR_J.
- WR_J: mem_address=j, mem_data=si, mem_wren=1. Go to NEXT.
- NEXT: if i==LAST_INDEX, go to DONE. Otherwise i←i+1 and go to REQ.
- DONE: done=1 for one cycle, then go to IDLE.
- Key capture: in WAIT_I or WAIT_KEY, key_finish=1 sets key_r←key_byte and key_valid←1. key_finish in any other state is ignored.
- When i==j, both writes go to the same address. The second write (si) wins, so S is unchanged.
- start while busy=1 is ignored. There is no abort other than reset.

## Timing
- Reset (asynchronous): state=IDLE; i, j, si, sj, key_r, key_valid = 0.
- Outputs during reset: busy, done, key_start, key_index, mem_address, mem_data, mem_wren all 0.
- Reset mid-pass: RAM contents are left partially shuffled. The next start begins again from i=0, j=0.
- Pass start: start sampled high in cycle 0 → REQ in cycle 1.
- Iteration length: max(L,2)+6 cycles.
  - L = cycles from the key_start cycle to the key_finish cycle, L≥1.
  - With the standard secretkey provider, L=6, so each iteration is 12 cycles.
- Full pass: 1 + (LAST_INDEX+1)·(max(L,2)+6) cycles from start to the done pulse. done is followed by IDLE on the next cycle.
- key_start is never asserted while a request is outstanding. Exactly one request is made per i.
- mem_wren is high only in WR_I and WR_J, exactly two cycles per iteration.

## Test plan
- Basic swaps:
  - Stimulus: identity S; mock provider returns bytes 00,02,49 for i mod 3 (L=6).
  - Iteration 0: j=00, S unchanged.
  - Iteration 1: j=03, so S[1]=03 and S[3]=01.
  - Iteration 2: j=4E, so S[2]=4E and S[4E]=02.
- Wrap-around: preload S[0]=FF, key byte FF → j=FE (not 1FE); writes S[0]=S_old[FE] and S[FE]=FF.
- Fast key: L=1, key_finish arrives during WAIT_I → key is latched, WAIT_KEY is 1 cycle, and the iteration is 8 cycles.
- Full pass against the golden model:
  - Setup: key 24'h000249, LAST_INDEX=255.
  - Final S matches the reference RC4 KSA.
  - done pulses once, 1+256·12 cycles after start.
  - 256 key_start pulses are observed.
- Reset mid-pass: assert reset_n=0 during WR_I of i=5 → outputs are 0 immediately. A restart begins at key_index=0 with mem_wren low until WR_I.
- start held high throughout a pass → no extra requests; after done, IDLE re-samples start and a new pass begins one cycle later.
